// File: rtl/motor_ramp.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp
// Brief    : Slew-rate limiter for the left/right drive commands feeding
//            motor_cntrl, with a level emergency stop that ramps both sides
//            to zero. Optional macro MOTOR_RAMP_FAST_DECEL_EN enables
//            double-rate steps toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module motor_ramp #(
    parameter int RAMP_DIV = 1024,
    parameter int STEP     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_vld,
    input  logic signed [10:0] cmd_lft,
    input  logic signed [10:0] cmd_rht,
    output logic               cmd_rdy,
    input  logic               estop,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht,
    output logic               ramp_done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ramp = 2'd1;
    localparam logic [1:0] c_st_stop = 2'd2;

    localparam logic [15:0]        c_presc_max = 16'(RAMP_DIV - 1);
    localparam logic signed [11:0] c_step      = 12'(STEP);
`ifdef MOTOR_RAMP_FAST_DECEL_EN
    localparam logic signed [11:0] c_step_dec  = 12'(2 * STEP);
`endif

    logic [1:0]         r_state;
    logic [15:0]        r_presc;
    logic signed [10:0] r_tgt_lft;
    logic signed [10:0] r_tgt_rht;
    logic signed [10:0] r_lft;
    logic signed [10:0] r_rht;
    logic               r_done;

    logic               w_accept;
    logic               w_tick;
    logic               w_upd;
    logic signed [10:0] w_nxt_lft;
    logic signed [10:0] w_nxt_rht;
    logic               w_at_tgt;
    logic               w_at_zero;

    // One tick's worth of movement from cur toward tgt; all math is done in
    // 12 bits so the difference of two 11-bit extremes cannot wrap.
    function automatic logic signed [10:0] f_approach(
        input logic signed [10:0] cur,
        input logic signed [10:0] tgt
    );
        logic signed [11:0] v_cur;
        logic signed [11:0] v_dif;
        logic signed [11:0] v_mag;
        logic signed [11:0] v_lim;
        logic signed [11:0] v_stp;
        logic signed [11:0] v_res;
        v_cur = 12'(cur);
        v_dif = 12'(tgt) - v_cur;
        v_mag = (v_dif < 0) ? -v_dif : v_dif;
        v_lim = c_step;
`ifdef MOTOR_RAMP_FAST_DECEL_EN
        // Decelerating: double rate, but stop at zero so a sign change
        // always restarts from zero at the normal rate.
        if ((v_cur > 0 && v_dif < 0) || (v_cur < 0 && v_dif > 0)) begin
            v_lim = c_step_dec;
            if (v_cur > 0 && v_cur < v_lim) begin
                v_lim = v_cur;
            end
            if (v_cur < 0 && -v_cur < v_lim) begin
                v_lim = -v_cur;
            end
        end
`endif
        v_stp = (v_mag < v_lim) ? v_mag : v_lim;
        v_res = (v_dif < 0) ? (v_cur - v_stp) : (v_cur + v_stp);
        return 11'(v_res);
    endfunction

    assign cmd_rdy  = (r_state != c_st_stop) && !estop;
    assign w_accept = cmd_vld && cmd_rdy;
    assign w_tick   = (r_presc == c_presc_max);

    // A freshly accepted command restarts the tick phase, so no movement on
    // the acceptance edge itself.
    assign w_upd = w_tick && !w_accept && (r_state != c_st_idle);

    assign w_nxt_lft = w_upd ? f_approach(r_lft, r_tgt_lft) : r_lft;
    assign w_nxt_rht = w_upd ? f_approach(r_rht, r_tgt_rht) : r_rht;

    assign w_at_tgt  = (w_nxt_lft == r_tgt_lft) && (w_nxt_rht == r_tgt_rht);
    assign w_at_zero = (r_lft == 11'sd0) && (r_rht == 11'sd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_presc   <= 16'd0;
            r_tgt_lft <= 11'sd0;
            r_tgt_rht <= 11'sd0;
            r_lft     <= 11'sd0;
            r_rht     <= 11'sd0;
            r_done    <= 1'b0;
        end else begin
            r_lft  <= w_nxt_lft;
            r_rht  <= w_nxt_rht;
            r_done <= 1'b0;

            if (w_accept || w_tick) begin
                r_presc <= 16'd0;
            end else begin
                r_presc <= r_presc + 16'd1;
            end

            if (estop) begin
                r_tgt_lft <= 11'sd0;
                r_tgt_rht <= 11'sd0;
                r_state   <= c_st_stop;
            end else if (w_accept) begin
                r_tgt_lft <= cmd_lft;
                r_tgt_rht <= cmd_rht;
                r_state   <= c_st_ramp;
            end else begin
                case (r_state)
                    c_st_ramp: begin
                        if (w_upd && w_at_tgt) begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end
                    c_st_stop: begin
                        if (w_at_zero) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign lft       = r_lft;
    assign rht       = r_rht;
    assign ramp_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_ramp
// Brief    : Self-checking bench for motor_ramp: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_ramp;

    localparam int RAMP_DIV = 4;
    localparam int STEP     = 8;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_STOP = 2;

    logic               clk;
    logic               rst;
    logic               cmd_vld;
    logic signed [10:0] cmd_lft;
    logic signed [10:0] cmd_rht;
    logic               cmd_rdy;
    logic               estop;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               ramp_done;

    int n_cmp;
    int n_err;

    // reference model state
    int m_lft, m_rht, m_tl, m_tr, m_mode, m_cnt, m_done;

    motor_ramp #(
        .RAMP_DIV (RAMP_DIV),
        .STEP     (STEP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_lft   (cmd_lft),
        .cmd_rht   (cmd_rht),
        .cmd_rdy   (cmd_rdy),
        .estop     (estop),
        .lft       (lft),
        .rht       (rht),
        .ramp_done (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int approach(input int cur, input int tgt);
        int d, s;
        d = tgt - cur;
        s = imin(STEP, iabs(d));
`ifdef MOTOR_RAMP_FAST_DECEL_EN
        if ((cur > 0 && d < 0) || (cur < 0 && d > 0))
            s = imin(imin(2 * STEP, iabs(d)), iabs(cur));
`endif
        return (d < 0) ? cur - s : cur + s;
    endfunction

    function automatic bit model_rdy();
        return (m_mode != M_STOP) && !estop;
    endfunction

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic step();
        bit acc, tick;
        int nl, nr;
        acc  = cmd_vld && model_rdy();
        tick = (m_cnt == RAMP_DIV - 1);
        if (rst) begin
            m_lft = 0; m_rht = 0; m_tl = 0; m_tr = 0;
            m_mode = M_IDLE; m_cnt = 0; m_done = 0;
        end else begin
            nl = m_lft;
            nr = m_rht;
            if (tick && !acc && m_mode != M_IDLE) begin
                nl = approach(m_lft, m_tl);
                nr = approach(m_rht, m_tr);
            end
            m_done = 0;
            if (estop) begin
                m_tl = 0; m_tr = 0; m_mode = M_STOP;
            end else if (acc) begin
                m_tl = int'(cmd_lft); m_tr = int'(cmd_rht); m_mode = M_RAMP;
            end else if (m_mode == M_RAMP && tick && nl == m_tl && nr == m_tr) begin
                m_mode = M_IDLE; m_done = 1;
            end else if (m_mode == M_STOP && m_lft == 0 && m_rht == 0) begin
                m_mode = M_IDLE;
            end
            m_cnt = acc ? 0 : (m_cnt + 1) % RAMP_DIV;
            m_lft = nl;
            m_rht = nr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input int l, input int r);
        cmd_vld = 1'b1;
        cmd_lft = 11'(l);
        cmd_rht = 11'(r);
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (lft !== 11'sd0 || rht !== 11'sd0 || ramp_done !== 1'b0 || cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got lft=%0d rht=%0d done=%b rdy=%b, need 0 0 0 1",
                     lft, rht, ramp_done, cmd_rdy);
        end
        issue(300, -300);
        repeat (10) step();
        estop = 1'b1;
        cmd_vld = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; estop = 1'b0; cmd_vld = 1'b0;
        #1;
        n_cmp++;
        if (lft !== 11'sd0 || rht !== 11'sd0 || ramp_done !== 1'b0 || cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_midramp: got lft=%0d rht=%0d done=%b rdy=%b, need 0 0 0 1",
                     lft, rht, ramp_done, cmd_rdy);
        end
        repeat (8) step();
        n_cmp++;
        if (lft !== 11'sd0 || rht !== 11'sd0) begin
            n_err++;
            $display("FAIL reset_idle_hold: got lft=%0d rht=%0d, need 0 0", lft, rht);
        end
    endtask

    task automatic test_basic_ramp();
        int pulses;
        apply_reset();
        issue(100, -50);
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (ramp_done === 1'b1) pulses++;
            if (k == 24) begin
                n_cmp++;
                if (rht !== -11'sd48) begin
                    n_err++;
                    $display("FAIL basic_rht_tick6: got %0d, need -48", rht);
                end
            end
            if (k == 28) begin
                n_cmp++;
                if (rht !== -11'sd50) begin
                    n_err++;
                    $display("FAIL basic_rht_tick7: got %0d, need -50", rht);
                end
            end
            if (k == 48) begin
                n_cmp++;
                if (lft !== 11'sd96 || ramp_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_tick12: got lft=%0d done=%b, need 96 0", lft, ramp_done);
                end
            end
            if (k == 52) begin
                n_cmp++;
                if (lft !== 11'sd100 || ramp_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL basic_tick13: got lft=%0d done=%b, need 100 1", lft, ramp_done);
                end
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL basic_done_count: got %0d pulses, need 1", pulses);
        end
    endtask

    task automatic test_retarget();
        int pulses;
        apply_reset();
        issue(200, 0);
        repeat (20) step();
        n_cmp++;
        if (lft !== 11'sd40) begin
            n_err++;
            $display("FAIL retarget_start: got lft=%0d, need 40", lft);
        end
        issue(-16, 0);
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ramp_done === 1'b1) pulses++;
`ifndef MOTOR_RAMP_FAST_DECEL_EN
            if (k % RAMP_DIV == 0 && k / RAMP_DIV <= 7) begin
                n_cmp++;
                if (int'(lft) !== 40 - 8 * (k / RAMP_DIV)) begin
                    n_err++;
                    $display("FAIL retarget_tick%0d: got lft=%0d, need %0d",
                             k / RAMP_DIV, lft, 40 - 8 * (k / RAMP_DIV));
                end
            end
`endif
        end
        n_cmp++;
        if (pulses != 1 || lft !== -11'sd16) begin
            n_err++;
            $display("FAIL retarget_end: got lft=%0d pulses=%0d, need -16 1", lft, pulses);
        end
    endtask

    task automatic test_estop();
        int pulses;
        apply_reset();
        issue(96, -96);
        repeat (50) step();
        estop = 1'b1;
        cmd_vld = 1'b1;
        cmd_lft = 11'sd500;
        cmd_rht = 11'sd500;
        #1;
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL estop_rdy: got %b, need 0", cmd_rdy);
        end
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (ramp_done === 1'b1) pulses++;
            if (k == 1) cmd_vld = 1'b0;
        end
        n_cmp++;
        if (lft !== 11'sd0 || rht !== 11'sd0 || cmd_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL estop_zero: got lft=%0d rht=%0d rdy=%b, need 0 0 0", lft, rht, cmd_rdy);
        end
        estop = 1'b0;
        step();
        n_cmp++;
        if (cmd_rdy !== 1'b1 || pulses != 0 || ramp_done !== 1'b0) begin
            n_err++;
            $display("FAIL estop_release: got rdy=%b pulses=%0d, need 1 0", cmd_rdy, pulses);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        issue(-1024, 1023);
        for (int k = 1; k <= 530; k++) begin
            step();
            n_cmp++;
            if (int'(lft) !== m_lft || int'(rht) !== m_rht || int'(lft) > 0 || int'(rht) < 0) begin
                n_err++;
                $display("FAIL saturate_cyc%0d: got lft=%0d rht=%0d, need %0d %0d",
                         k, lft, rht, m_lft, m_rht);
            end
        end
        n_cmp++;
        if (lft !== -11'sd1024 || rht !== 11'sd1023) begin
            n_err++;
            $display("FAIL saturate_end: got lft=%0d rht=%0d, need -1024 1023", lft, rht);
        end
    endtask

`ifdef MOTOR_RAMP_FAST_DECEL_EN
    task automatic test_fast_decel();
        int exp_seq [8] = '{48, 32, 16, 0, -8, -16, -24, -32};
        apply_reset();
        issue(64, 0);
        repeat (40) step();
        issue(-32, 0);
        for (int t = 0; t < 8; t++) begin
            repeat (RAMP_DIV) step();
            n_cmp++;
            if (int'(lft) !== exp_seq[t]) begin
                n_err++;
                $display("FAIL fast_decel_tick%0d: got lft=%0d, need %0d", t + 1, lft, exp_seq[t]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int estop_hold;
        apply_reset();
        estop_hold = 0;
        for (int k = 0; k < 4000; k++) begin
            cmd_vld = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cmd_lft = 11'($urandom_range(0, 2047));
                cmd_rht = 11'($urandom_range(0, 2047));
            end else begin
                cmd_lft = 11'(int'($urandom_range(0, 160)) - 80);
                cmd_rht = 11'(int'($urandom_range(0, 160)) - 80);
            end
            if (estop_hold > 0) begin
                estop_hold--;
            end else if ($urandom_range(0, 299) == 0) begin
                estop_hold = $urandom_range(1, 120);
            end
            estop = (estop_hold > 0);
            rst   = ($urandom_range(0, 1499) == 0);
            #1;
            n_cmp++;
            if (cmd_rdy !== model_rdy()) begin
                n_err++;
                $display("FAIL rand_rdy_cyc%0d: got %b, need %b", k, cmd_rdy, model_rdy());
            end
            step();
            n_cmp++;
            if (int'(lft) !== m_lft || int'(rht) !== m_rht || int'(ramp_done) !== m_done) begin
                n_err++;
                $display("FAIL rand_out_cyc%0d: got lft=%0d rht=%0d done=%b, need %0d %0d %0d",
                         k, lft, rht, ramp_done, m_lft, m_rht, m_done);
            end
        end
        rst = 1'b0; estop = 1'b0; cmd_vld = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0;
        cmd_lft = 11'sd0; cmd_rht = 11'sd0;
        m_lft = 0; m_rht = 0; m_tl = 0; m_tr = 0;
        m_mode = M_IDLE; m_cnt = 0; m_done = 0;
        #2;
        test_reset();
        test_basic_ramp();
        test_retarget();
        test_estop();
        test_saturate();
`ifdef MOTOR_RAMP_FAST_DECEL_EN
        test_fast_decel();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_ramp.md
MOTOR_RAMP -- requirements
Module: motor_ramp

Interface
REQ-001 Parameter RAMP_DIV, default 1024, clocks per ramp tick (legal 2..65535).
REQ-002 Parameter STEP, default 8, max per-tick output change in LSBs (legal 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_vld  input  1  target command valid.
REQ-006 cmd_lft  input  11  signed left target, two's complement, -1024..1023.
REQ-007 cmd_rht  input  11  signed right target, same format.
REQ-008 cmd_rdy  output  1  block accepts a command this cycle.
REQ-009 estop  input  1  level emergency stop, ramp both sides to zero.
REQ-010 lft  output  11  signed left drive to motor_cntrl, registered.
REQ-011 rht  output  11  signed right drive to motor_cntrl, registered.
REQ-012 ramp_done  output  1  one-cycle pulse when both outputs reach targets.

Function
REQ-013 States SHALL be IDLE, RAMP, STOP, held in a registered state machine.
REQ-014 Command SHALL be accepted on any cycle with cmd_vld=1 and cmd_rdy=1; targets latched at that edge.
REQ-015 cmd_rdy SHALL be 1 in IDLE and RAMP, 0 in STOP; combinational from state and estop (0 whenever estop=1).
REQ-016 Acceptance SHALL move state to RAMP and clear the prescaler; new target mid-RAMP replaces the old, outputs continue from current values.
REQ-017 Prescaler SHALL count 0..RAMP_DIV-1 and wrap; tick asserted on the cycle count==RAMP_DIV-1; first tick exactly RAMP_DIV clocks after acceptance edge.
REQ-018 On tick in RAMP or STOP, each side SHALL move toward its target by min(STEP, |target-current|); no change on non-tick cycles or in IDLE.
REQ-019 Difference and step arithmetic SHALL use 12-bit signed; outputs never overshoot target nor leave -1024..1023.
REQ-020 On a tick where both outputs equal targets after update, RAMP SHALL go to IDLE and ramp_done SHALL pulse for exactly that following cycle.
REQ-021 Command equal to current outputs SHALL still enter RAMP; ramp_done pulses after the first tick.
REQ-022 estop=1 in any state SHALL force targets to 0 and state to STOP on the next edge.
REQ-023 estop and accepted command on the same cycle: estop wins, command discarded (cmd_rdy already 0).
REQ-024 STOP SHALL go to IDLE when lft=rht=0 and estop=0; ramp_done SHALL NOT pulse on STOP exit.
REQ-025 Sides SHALL ramp independently; side reaching target first holds while the other continues.

Reset
REQ-026 rst=1 SHALL set state IDLE, prescaler 0, targets 0, lft=0, rht=0, ramp_done=0 at the next edge.
REQ-027 rst SHALL override estop, cmd_vld and any in-progress ramp; cmd_rdy=1 in the first cycle after reset if estop=0.

Configuration
REQ-028 Macro MOTOR_RAMP_FAST_DECEL_EN SHALL select asymmetric deceleration.
REQ-029 Defined: step toward zero (current>0 moving down, or current<0 moving up) SHALL be min(2*STEP, |target-current|, |current|); zero crossing splits across ticks, acceleration from zero uses STEP.
REQ-030 Undefined: all steps SHALL use STEP per REQ-018; no extra logic synthesized.

Verification (RAMP_DIV=4, STEP=8, macro undefined unless stated)
REQ-031 rst pulse mid-ramp -> next cycle lft=0, rht=0, ramp_done=0, cmd_rdy=1, state IDLE.
REQ-032 Accept lft=100, rht=-50 from 0 -> rht=-50 after tick 7 (-48 then -50); lft=100 after tick 13; ramp_done single pulse 52 clocks plus one after acceptance.
REQ-033 Ramping to lft=200, new command lft=-16 at lft=40 -> lft decreases 8/tick from 40 to -16 without reset to 0; one ramp_done.
REQ-034 At lft=96, rht=-96, assert estop with cmd_vld=1 -> cmd_rdy=0, command ignored, both reach 0 after 12 ticks, state IDLE after estop release, no ramp_done.
REQ-035 Targets -1024 and 1023 from 0 -> outputs saturate exactly at -1024 and 1023, no wrap.
REQ-036 MOTOR_RAMP_FAST_DECEL_EN defined, lft=64 to -32 -> 48,32,16,0,-8,-16,-24,-32 on successive ticks.
